imem_banked: RTL

IMEM_BANKED -- requirements
Module: imem_banked

---
 rtl/imem_banked.sv | 88 ++++++++
 1 files changed

// File: rtl/imem_banked.sv
// Banked single-entry-per-bank instruction store with occupancy tracking and sticky error flags.
// Optional macro IMEM_BANKED_BYPASS_EN lets a read of an empty bank return same-cycle write data.
module imem_banked #(
    parameter int WIDTH     = 256,
    parameter int BANK_BITS = 2
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      wr,
    input  logic [BANK_BITS-1:0]      wr_bank,
    input  logic [WIDTH-1:0]          in,
    output logic                      wr_ack,
    input  logic                      rd,
    input  logic [BANK_BITS-1:0]      rd_bank,
    input  logic                      rd_free,
    output logic [WIDTH-1:0]          out,
    output logic                      out_valid,
    output logic [(2**BANK_BITS)-1:0] full_mask,
    output logic [BANK_BITS:0]        count,
    output logic                      err_ovf,
    output logic                      err_udf
);

    localparam int NBANK = 2 ** BANK_BITS;

    logic [WIDTH-1:0]   mem [NBANK];
    logic               wr_accept;
    logic               rd_accept;
    logic               rd_bypass;
    logic               rd_hit;
    logic [NBANK-1:0]   mask_next;
    logic [BANK_BITS:0] count_next;

    // All accept decisions use the occupancy flags as they stood before this edge.
    always_comb begin
        wr_accept = wr && !full_mask[wr_bank];
        rd_accept = rd && full_mask[rd_bank];
`ifdef IMEM_BANKED_BYPASS_EN
        rd_bypass = rd && !full_mask[rd_bank] && wr_accept && (wr_bank == rd_bank);
`else
        rd_bypass = 1'b0;
`endif
        rd_hit = rd_accept || rd_bypass;

        // Set before clear so a bypassed read with rd_free leaves the bank empty.
        mask_next = full_mask;
        if (wr_accept)
            mask_next[wr_bank] = 1'b1;
        if (rd_hit && rd_free)
            mask_next[rd_bank] = 1'b0;

        count_next = '0;
        for (int i = 0; i < NBANK; i++)
            count_next = count_next + {{BANK_BITS{1'b0}}, mask_next[i]};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            full_mask <= '0;
            count     <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            wr_ack    <= 1'b0;
            err_ovf   <= 1'b0;
            err_udf   <= 1'b0;
        end else begin
            full_mask <= mask_next;
            count     <= count_next;
            wr_ack    <= wr_accept;
            out_valid <= rd_hit;
            if (rd_accept)
                out <= mem[rd_bank];
            else if (rd_bypass)
                out <= in;
            if (wr && full_mask[wr_bank])
                err_ovf <= 1'b1;
            if (rd && !full_mask[rd_bank] && !rd_bypass)
                err_udf <= 1'b1;
        end
    end

    // Storage is deliberately not reset; a write during reset is unobservable since all banks read empty.
    always_ff @(posedge clock) begin
        if (wr_accept)
            mem[wr_bank] <= in;
    end

endmodule
